// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: formats, opcode maps,
// request bundle and small immediate helpers.
package inst_encoder_pkg;

    typedef logic [31:0] word;
    typedef logic [31:0] instr_t;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_LI = 3'd6
    } enc_fmt_t;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_PEND = 2'd2
    } enc_state_t;

    // Opcode bits [6:2] as used by decode; bits [1:0] are always 2'b11.
    localparam logic [4:0] ISA_OPMAP_LOAD   = 5'b00000;
    localparam logic [4:0] ISA_OPMAP_OP_IMM = 5'b00100;
    localparam logic [4:0] ISA_OPMAP_AUIPC  = 5'b00101;
    localparam logic [4:0] ISA_OPMAP_STORE  = 5'b01000;
    localparam logic [4:0] ISA_OPMAP_OP     = 5'b01100;
    localparam logic [4:0] ISA_OPMAP_LUI    = 5'b01101;
    localparam logic [4:0] ISA_OPMAP_BRANCH = 5'b11000;
    localparam logic [4:0] ISA_OPMAP_JALR   = 5'b11001;
    localparam logic [4:0] ISA_OPMAP_JAL    = 5'b11011;

    localparam instr_t INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        enc_fmt_t   fmt;
        logic [4:0] opmap;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        word        imm;
    } enc_req_t;

    // Full 7-bit opcode from the opcode map.
    function automatic logic [6:0] opcode_of(input logic [4:0] opmap);
        return {opmap, 2'b11};
    endfunction

    // True when v is representable as a signed value of the given width.
    function automatic logic fits_signed(input word v, input int unsigned bits);
        word hi;
        hi = word'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_imm_encode.sv
// Scatters a full signed immediate into the instruction bit positions the
// decode-side immediate generator gathers from, and flags values that do
// not fit the chosen format.
module imm_encode
    import inst_encoder_pkg::*;
(
    input  enc_fmt_t fmt,
    input  word      imm,
    output instr_t   imm_bits,
    output logic     range_err
);

    // Per-format bit scatter and range check; R and LI carry no immediate here.
    always_comb begin
        imm_bits  = '0;
        range_err = 1'b0;
        case (fmt)
            FMT_I: begin
                imm_bits  = {imm[11:0], 20'b0};
                range_err = !fits_signed(imm, 12);
            end
            FMT_S: begin
                imm_bits  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                range_err = !fits_signed(imm, 12);
            end
            FMT_B: begin
                imm_bits  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                range_err = !fits_signed(imm, 13) || imm[0];
            end
            FMT_U: begin
                imm_bits  = {imm[31:12], 12'b0};
                range_err = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                imm_bits  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                range_err = !fits_signed(imm, 21) || imm[0];
            end
            default: begin
                imm_bits  = '0;
                range_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Field-level request to RV32I instruction encoder with LI expansion and a
// one-entry registered output stage plus a shadow slot for the LI's ADDI.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [4:0]  req_opmap,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        out_err
);

    enc_req_t   w_req;
    enc_state_t r_state;
    enc_state_t w_state_next;
    instr_t     w_imm_bits;
    logic       w_range_err;
    instr_t     w_fields;
    logic       w_is_li;
    logic       w_li_small;
    logic [19:0] w_li_upper;
    logic       w_two;
    instr_t     w_first;
    instr_t     w_second;
    logic       w_err;
    logic       w_accept;
    instr_t     r_inst;
    instr_t     r_shadow;
    logic       r_last;
    logic       r_err;

    assign w_req = '{fmt: enc_fmt_t'(req_fmt), opmap: req_opmap, rd: req_rd,
                     rs1: req_rs1, rs2: req_rs2, funct3: req_funct3,
                     funct7: req_funct7, imm: req_imm};

    imm_encode u_imm_encode (
        .fmt       (w_req.fmt),
        .imm       (w_req.imm),
        .imm_bits  (w_imm_bits),
        .range_err (w_range_err)
    );

    // Register/function fields kept by each format; the immediate is ORed in.
    always_comb begin
        w_fields = {w_req.funct7, w_req.rs2, w_req.rs1, w_req.funct3, w_req.rd,
                    opcode_of(w_req.opmap)};
        case (w_req.fmt)
            FMT_I:        w_fields = {12'b0, w_req.rs1, w_req.funct3, w_req.rd,
                                      opcode_of(w_req.opmap)};
            FMT_S, FMT_B: w_fields = {7'b0, w_req.rs2, w_req.rs1, w_req.funct3, 5'b0,
                                      opcode_of(w_req.opmap)};
            FMT_U, FMT_J: w_fields = {20'b0, w_req.rd, opcode_of(w_req.opmap)};
            default:      ;
        endcase
    end

    // (imm + 0x800)[31:12] equals imm[31:12] + imm[11], wrapping at 2^20.
    assign w_is_li    = (w_req.fmt == FMT_LI);
    assign w_li_small = fits_signed(w_req.imm, 12);
    assign w_li_upper = w_req.imm[31:12] + {19'b0, w_req.imm[11]};
    assign w_two      = w_is_li && !w_li_small && (w_req.imm[11:0] != 12'd0);
    assign w_err      = CHECK_RANGE && !w_is_li && w_range_err;

    // First emitted word and the ADDI that may follow an LUI.
    always_comb begin
        w_second = {w_req.imm[11:0], w_req.rd, 3'b000, w_req.rd, opcode_of(ISA_OPMAP_OP_IMM)};
        if (!w_is_li) begin
            w_first = w_fields | w_imm_bits;
        end else if (w_li_small) begin
            w_first = {w_req.imm[11:0], 5'd0, 3'b000, w_req.rd, opcode_of(ISA_OPMAP_OP_IMM)};
        end else begin
            w_first = {w_li_upper, w_req.rd, opcode_of(ISA_OPMAP_LUI)};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY:     if (w_accept) w_state_next = w_two ? FULL_PEND : FULL;
            FULL:      if (out_ready) w_state_next = w_accept ? (w_two ? FULL_PEND : FULL) : EMPTY;
            FULL_PEND: if (out_ready) w_state_next = FULL;
            default:   w_state_next = EMPTY;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        req_ready = ((r_state == EMPTY) || ((r_state == FULL) && out_ready)) && !rst;
        out_valid = (r_state != EMPTY);
        w_accept  = req_valid && req_ready;
    end

    // Output and shadow registers: load on accept, promote the ADDI after an LUI drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst   <= INSTR_NOP;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
            r_shadow <= '0;
        end else if (w_accept) begin
            r_inst   <= w_first;
            r_last   <= !w_two;
            r_err    <= w_err;
            r_shadow <= w_two ? w_second : '0;
        end else if ((r_state == FULL_PEND) && out_ready) begin
            r_inst   <= r_shadow;
            r_last   <= 1'b1;
            r_err    <= 1'b0;
            r_shadow <= '0;
        end
    end

    assign out_inst = r_inst;
    assign out_last = r_last;
    assign out_err  = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases plus randomized
// requests scored against an arithmetic reference model.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready, req_ready_nc;
    logic [2:0]  req_fmt;
    logic [4:0]  req_opmap, req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [31:0] req_imm;
    logic        out_valid, out_valid_nc;
    logic        out_ready;
    logic [31:0] out_inst, out_inst_nc;
    logic        out_last, out_last_nc;
    logic        out_err, out_err_nc;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic [31:0] last_inst;

    typedef struct {logic [31:0] inst; logic last; logic err; logic err_nc; int cyc;} obs_t;
    typedef struct {logic [31:0] inst; logic last; logic err;} exp_t;
    obs_t obs_q[$];
    exp_t exp_q[$];

    inst_encoder #(.CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_opmap(req_opmap), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_last(out_last), .out_err(out_err)
    );

    inst_encoder #(.CHECK_RANGE(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_nc),
        .req_fmt(req_fmt), .req_opmap(req_opmap), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .out_valid(out_valid_nc), .out_ready(out_ready), .out_inst(out_inst_nc),
        .out_last(out_last_nc), .out_err(out_err_nc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only just after posedge, so a negedge sample predicts the next handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            obs_q.push_back('{out_inst, out_last, out_err, out_err_nc, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic last, input logic err);
        exp_q.push_back('{inst, last, err});
    endtask

    // Reference model: encoding rules written as plain shifts and masks.
    function automatic void model(input logic [2:0] fmt, input logic [4:0] opmap,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] imm);
        int signed   s;
        logic [31:0] opc, regs, w, hi;
        logic        e;
        s    = $signed(imm);
        opc  = 32'(opmap) * 4 + 3;
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        e    = 1'b0;
        w    = '0;
        case (fmt)
            3'd0: w = (32'(f7) << 25) | regs | (32'(rd) << 7) | opc;
            3'd1: begin
                w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | opc;
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | opc;
                e = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | opc;
                e = (s < -4096) || (s > 4095) || (imm % 2 != 0);
            end
            3'd4: begin
                w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | opc;
                e = (imm & 32'hFFF) != 0;
            end
            3'd5: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | opc;
                e = (s < -(1 << 20)) || (s >= (1 << 20)) || (imm % 2 != 0);
            end
            default: ;
        endcase
        if (fmt != 3'd6) begin
            exp_q.push_back('{w, 1'b1, e});
        end else if (s >= -2048 && s <= 2047) begin
            exp_q.push_back('{((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13, 1'b1, 1'b0});
        end else begin
            hi = (imm + 32'h800) >> 12;
            exp_q.push_back('{(hi << 12) | (32'(rd) << 7) | 32'h37, (imm & 32'hFFF) == 0, 1'b0});
            if ((imm & 32'hFFF) != 0)
                exp_q.push_back('{((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13,
                                  1'b1, 1'b0});
        end
    endfunction

    task automatic issue(input logic [2:0] fmt, input logic [4:0] opmap, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input bit use_model, input bit rand_rdy);
        bit accepted;
        req_fmt = fmt; req_opmap = opmap; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_funct7 = f7; req_imm = imm;
        req_valid = 1'b1;
        if (use_model) model(fmt, opmap, rd, rs1, rs2, f3, f7, imm);
        accepted = 1'b0;
        for (int k = 0; k < 200 && !accepted; k++) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        compared++;
        assert (accepted) else begin
            mismatched++;
            $error("FAIL accept_timeout: observed %0d expected %0d", accepted, 1);
        end
    endtask

    task automatic drain(input string tag, input bit b2b, input bit rnd);
        obs_t o;
        exp_t x;
        int   prev;
        prev = -1;
        for (int k = 0; k < 1000 && obs_q.size() < exp_q.size(); k++) begin
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            chk({tag, "_inst"}, o.inst, x.inst);
            chk({tag, "_last"}, 32'(o.last), 32'(x.last));
            chk({tag, "_err"}, 32'(o.err), 32'(x.err));
            chk({tag, "_err_nochk"}, 32'(o.err_nc), 32'd0);
            if (b2b && prev >= 0) chk({tag, "_gap"}, 32'(o.cyc - prev), 32'd1);
            prev = o.cyc;
            last_inst = o.inst;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] gathered;
        logic [31:0] bnd [13];
        logic [31:0] imm;
        bnd = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
                32'hFFFFF000, 32'h7FFFF800, 32'h000FFFFE, 32'hFFF00000, 32'h00100000,
                32'h00001000, 32'h12345FFF};
        rst = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        req_fmt = '0; req_opmap = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_funct3 = '0; req_funct7 = '0; req_imm = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", out_inst, 32'h00000013);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Four back-to-back ADD x3,x1,x2.
        repeat (4) push_exp(32'h002081B3, 1'b1, 1'b0);
        repeat (4) issue(3'd0, 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0);
        drain("r_add", 1'b1, 1'b0);

        push_exp(32'hFFF10093, 1'b1, 1'b0);
        issue(3'd1, 5'b00100, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        drain("i_addi", 1'b0, 1'b0);

        push_exp(32'hFE208EE3, 1'b1, 1'b0);
        issue(3'd3, 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 1'b0);
        drain("b_beq", 1'b0, 1'b0);
        gathered = {{19{last_inst[31]}}, last_inst[31], last_inst[7], last_inst[30:25],
                    last_inst[11:8], 1'b0};
        chk("b_decode", gathered, 32'hFFFFFFFC);

        push_exp(32'h80312023, 1'b1, 1'b1);
        issue(3'd2, 5'b01000, 5'd0, 5'd2, 5'd3, 3'b010, 7'd0, 32'h00000800, 1'b0, 1'b0);
        drain("s_sw", 1'b0, 1'b0);

        // LI split with the output stalled between the two words.
        out_ready = 1'b0;
        push_exp(32'h123462B7, 1'b0, 1'b0);
        push_exp(32'hFFF28293, 1'b1, 1'b0);
        issue(3'd6, 5'b10101, 5'd5, 5'd7, 5'd9, 3'd3, 7'h55, 32'h12345FFF, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_inst", out_inst, 32'h123462B7);
            chk("stall_last", 32'(out_last), 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain("li_split", 1'b0, 1'b0);

        // LI boundaries: wrap to LUI 0x80000, LUI-only, and single ADDI.
        push_exp(32'h800000B7, 1'b0, 1'b0);
        push_exp(32'h80008093, 1'b1, 1'b0);
        issue(3'd6, 5'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FFFF800, 1'b0, 1'b0);
        push_exp(32'h00001137, 1'b1, 1'b0);
        issue(3'd6, 5'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 1'b0, 1'b0);
        push_exp(32'h80000193, 1'b1, 1'b0);
        issue(3'd6, 5'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b0, 1'b0);
        drain("li_bound", 1'b1, 1'b0);

        // Asynchronous reset while an ADDI is pending.
        out_ready = 1'b0;
        issue(3'd6, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("pend_valid", 32'(out_valid), 32'd1);
        chk("pend_ready", 32'(req_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_inst", out_inst, 32'h00000013);
        chk("arst_last", 32'(out_last), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        push_exp(32'hFFF10093, 1'b1, 1'b0);
        issue(3'd1, 5'b00100, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        drain("post_rst", 1'b0, 1'b0);

        // Randomized requests against the reference model with random backpressure.
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = $urandom & 32'hFFFFF000;
                default: imm = bnd[$urandom_range(0, 12)];
            endcase
            issue(3'($urandom_range(0, 6)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                  7'($urandom_range(0, 127)), imm, 1'b1, 1'b1);
        end
        drain("rand", 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Encodes field-level instruction requests into 32-bit RV32I `instr_t` words, scattering the immediate into the R/I/S/B/U/J bit positions that the decode-side immediate generator gathers from. It expands the `LI` pseudo-op into one or two real instructions. It feeds debug-module instruction injection and test stimulus generation. Valid/ready handshakes on both sides, with a one-entry registered output stage.

## Interface
- `CHECK_RANGE`, default 1: when 1, out-of-range immediates raise `out_err`; when 0, `out_err` is tied to 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle where `req_valid && req_ready`.
- `req_fmt` in 3: `enc_fmt_t`, one of `FMT_R`, `FMT_I`, `FMT_S`, `FMT_B`, `FMT_U`, `FMT_J`, `FMT_LI`.
- `req_opmap` in 5: opcode bits [6:2]; bits [1:0] are always 2'b11.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register fields.
- `req_funct3` in 3, `req_funct7` in 7: function fields.
- `req_imm` in 32 (`word`): full signed immediate value, not pre-shifted.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_inst` out 32 (`instr_t`): encoded instruction.
- `out_last` out 1: last word of the request.
- `out_err` out 1: the immediate did not fit. The word is still emitted, with the immediate truncated.

## Operation
- Fields placed per format (R: funct7, rs2, rs1, funct3, rd; I: imm[11:0], rs1, funct3, rd; S/B: rs2, rs1, funct3 plus scattered immediate; U: imm[31:12], rd; J: scattered imm[20:1], rd). Unused fields are ignored.
- Shift-immediates: the caller places funct7 in `req_imm[11:5]`.
- Range rules:
  - I/S: signed 12-bit.
  - B: signed 13-bit with bit 0 = 0.
  - J: signed 21-bit with bit 0 = 0.
  - U: `imm[11:0]` = 0.
  - Any violation sets `out_err`.
- `FMT_LI` ignores opmap, rs1, rs2 and functs, and never sets `out_err`.
  - Immediate in [-2048, 2047]: emits one word, `ADDI rd, x0, imm`.
  - Otherwise: emits `LUI rd, (imm+0x800)[31:12]`, then `ADDI rd, rd, imm[11:0]`. The ADDI is omitted when `imm[11:0]` = 0.
- FSM states:
  - `EMPTY`: `out_valid` = 0.
  - `FULL`: holds the last word of a request.
  - `FULL_PEND`: holds an LUI; the ADDI is pending in a shadow register.
- Transitions:
  - `EMPTY` -> on accept, goes to `FULL`, or to `FULL_PEND` for a two-word LI.
  - `FULL` -> on `out_ready`, goes to `EMPTY`, or reloads from a simultaneous accept.
  - `FULL_PEND` -> on `out_ready`, loads the ADDI and goes to `FULL`.
- `req_ready` = (`EMPTY` || (`FULL` && `out_ready`)) && !`rst`. It is 0 in `FULL_PEND`.
- Output stability: `out_inst`, `out_last` and `out_err` hold steady while `out_valid && !out_ready`.

## Timing
- Latency: a request accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput: 1 word per cycle while `out_ready` is held at 1. A two-word LI occupies 2 output cycles.
- Reset values: `out_valid` 0, `out_inst` 32'h00000013 (NOP), `out_last` 0, `out_err` 0, state `EMPTY`, shadow register 0.
- Reset is asynchronous. Asserting it mid-operation, including in `FULL_PEND`, clears `out_valid` immediately, and a pending ADDI is discarded.
- Simultaneous accept and drain in `FULL` is legal and loses no word.
- All immediate arithmetic is 32-bit two's complement. `imm+0x800` wraps modulo 2^32, so 0x7FFFF800 yields LUI 0x80000.

## Structure
- Add to the shared definitions header: `enc_fmt_t` (3-bit enum), an `enc_req_t` packed struct bundling all `req_*` fields, and the `ISA_OPMAP_*` constants already used by decode.
- Sub-module `imm_encode` (combinational): takes `fmt` and `imm`, produces the immediate-bearing instruction bits plus a `range_err` flag. It is the exact inverse of the decode-side immediate generator.
- The top level holds the FSM, output register, shadow register and LI split logic.

## Test plan
- R-type ADD x3,x1,x2 (opmap 01100, f3 0, f7 0), 4 back-to-back with `out_ready` = 1 -> 0x002081B3 on 4 consecutive cycles, `out_last` = 1 each.
- I-type ADDI x1,x2,-1 -> 0xFFF10093, `out_err` 0.
- B-type BEQ x1,x2,imm=-4 -> 0xFE208EE3. Decoding it through the immediate generator returns 0xFFFFFFFC.
- S-type SW x3,2048(x2) (f3 010) -> 0x80312023 with `out_err` = 1. Same request with `CHECK_RANGE` = 0 -> `out_err` = 0.
- LI x5, 0x12345FFF -> 0x123462B7 (`out_last` 0), then 0xFFF28293 (`out_last` 1). `out_ready` low for 3 cycles between the two words -> words held stable and `req_ready` = 0.
- Reset pulse while in `FULL_PEND` -> `out_valid` drops asynchronously, and after release the next request emits with no stale ADDI.
